twos_to_sm_bcd: RTL and testbench

TWOS_TO_SM_BCD -- requirements
Module: twos_to_sm_bcd

---
 rtl/twos_to_sm_bcd.sv | 128 ++++++++++++
 tb/tb_twos_to_sm_bcd.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/twos_to_sm_bcd.sv
// Sequential converter: 8-bit two's complement to sign + 3-digit BCD.
// NEG forms the magnitude, SHIFT runs 8 double-dabble steps, DONE publishes.
module twos_to_sm_bcd (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       sign,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    typedef enum logic [1:0] {
        IDLE,
        NEG,
        SHIFT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  din_q, din_d;
    logic [19:0] sreg_q, sreg_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sign_q, sign_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;

    logic [7:0]  mag;
    logic [19:0] adj;

    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Next-state, scratch datapath and published-result logic.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        mag     = din_q[7] ? (~din_q + 8'd1) : din_q;
        adj     = {dabble(sreg_q[19:16]),
                   dabble(sreg_q[15:12]),
                   dabble(sreg_q[11:8]),
                   sreg_q[7:0]};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    din_d   = din;
                    state_d = NEG;
                end
            end
            NEG: begin
                // -128 negates to 0x80, which is exactly the unsigned 128
                sgn_d   = din_q[7];
                sreg_d  = {12'd0, mag};
                cnt_d   = 3'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sreg_d = {adj[18:0], 1'b0};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                sign_d  = sgn_q;
                hund_d  = sreg_q[19:16];
                tens_d  = sreg_q[15:12];
                ones_d  = sreg_q[11:8];
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            din_q   <= '0;
            sreg_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sign_q  <= sign_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sign     = sign_q;
    assign bcd_hund = hund_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;

endmodule

// File: tb/tb_twos_to_sm_bcd.sv
// Bench for twos_to_sm_bcd: directed vector table, corner sequences
// and a full operand sweep with start held high.
module tb_twos_to_sm_bcd;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic       sign;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

    int total;
    int bad;

    typedef struct {
        logic [7:0] din;
        logic       s;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    vec_t vecs[12];

    twos_to_sm_bcd dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .sign     (sign),
        .bcd_hund (bcd_hund),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] res();
        return {3'b000, sign, bcd_hund, bcd_tens, bcd_ones};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the FSM idle; returns at the done negedge.
    task automatic run_conv(input logic [7:0] v, input logic es,
                            input logic [3:0] eh, input logic [3:0] et,
                            input logic [3:0] eo, input string nm);
        int k;
        int busy_n;
        int changed;
        logic seen;
        logic [15:0] hold;
        hold    = res();
        din     = v;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        din     = ~v;
        k       = 0;
        busy_n  = 0;
        changed = 0;
        seen    = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            else if (res() != hold) changed++;
        end
        chk({nm, "_lat"}, k, 11);
        chk({nm, "_busy"}, busy_n, 10);
        chk({nm, "_hold"}, changed, 0);
        chk({nm, "_res"}, int'(res()), int'({3'b000, es, eh, et, eo}));
    endtask

    logic [7:0] v8;
    int sv;
    int mag;
    int k;
    int dn;
    logic [15:0] r;

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{8'hFB, 1'b1, 4'd0, 4'd0, 4'd5};
        vecs[1]  = '{8'h80, 1'b1, 4'd1, 4'd2, 4'd8};
        vecs[2]  = '{8'h7F, 1'b0, 4'd1, 4'd2, 4'd7};
        vecs[3]  = '{8'h00, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[4]  = '{8'hFF, 1'b1, 4'd0, 4'd0, 4'd1};
        vecs[5]  = '{8'h0A, 1'b0, 4'd0, 4'd1, 4'd0};
        vecs[6]  = '{8'h63, 1'b0, 4'd0, 4'd9, 4'd9};
        vecs[7]  = '{8'h9C, 1'b1, 4'd1, 4'd0, 4'd0};
        vecs[8]  = '{8'h64, 1'b0, 4'd1, 4'd0, 4'd0};
        vecs[9]  = '{8'h81, 1'b1, 4'd1, 4'd2, 4'd7};
        vecs[10] = '{8'h01, 1'b0, 4'd0, 4'd0, 4'd1};
        vecs[11] = '{8'hF6, 1'b1, 4'd0, 4'd1, 4'd0};

        rst_n = 1'b0;
        start = 1'b0;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_out", int'({busy, done, res()}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].din, vecs[i].s, vecs[i].h,
                     vecs[i].t, vecs[i].o, $sformatf("vec%0d", i));
        end

        // Start re-pulsed mid-SHIFT must be ignored.
        din   = 8'h0A;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        din   = 8'h63;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn    = 0;
        r     = 16'hFFFF;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                r = res();
            end
        end
        chk("repulse_dones", dn, 1);
        chk("repulse_res", int'(r), int'(16'h0010));

        // Reset at SHIFT step 4 aborts the conversion.
        din   = 8'h9C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out", int'({busy, done, res()}), 0);
        start = 1'b1;
        @(negedge clk);
        chk("rst_vs_start", int'({busy, done}), 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("abort_quiet", dn, 0);
        rst_n = 1'b1;
        run_conv(8'h9C, 1'b1, 4'd1, 4'd0, 4'd0, "post_rst");

        // Full sweep with start held high; din scrambled after acceptance.
        start = 1'b1;
        for (int i = -128; i < 128; i++) begin
            v8  = i[7:0];
            din = v8;
            @(posedge clk);
            #1;
            din = 8'($urandom);
            k   = 0;
            while (!done && k < 20) begin
                @(negedge clk);
                k++;
            end
            sv  = i;
            mag = (sv < 0) ? -sv : sv;
            chk($sformatf("sweep_gap_%0d", i), k, 11);
            chk($sformatf("sweep_res_%0d", i), int'(res()),
                ((sv < 0) ? 4096 : 0) + (mag / 100) * 256 +
                ((mag / 10) % 10) * 16 + (mag % 10));
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
